bcd_display_driver: RTL and testbench
=====================================

Name: bcd_display_driver

Overview:
Downstream consumer of the 32-bit double-dabble converter output. It latches the 8-digit packed BCD word when a conversion completes and drives a time-multiplexed 8-digit common-anode 7-segment display. Features: configurable refresh prescaler, per-digit decimal points, optional leading-zero blanking and an invalid-digit indication. Sits between the converter and the board display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit before advancing; legal range >= 1; prescaler width $clog2(REFRESH_DIV), minimum 1 bit.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bcd_in  input  32  packed BCD from converter; digit i = bcd_in[4i+3:4i], digit 7 most significant
idle_in  input  1  converter idle flag; 0 while converting, 1 when result valid
enable  input  1  1 = display on; 0 = all anodes off, scanning continues
lzb  input  1  1 = leading-zero blanking enabled
dp_in  input  8  per-digit decimal point request, active high, bit i -> digit i
an  output  8  anode selects, active low, an[i] -> digit i
seg  output  7  cathodes, active low, order {g,f,e,d,c,b,a}
dp  output  1  decimal-point cathode, active low

Behaviour:
- Reset (clk edge with reset=1): an=8'hFF, seg=7'h7F, dp=1, bcd_q=0, idle_d=1, tick_cnt=0, digit_idx=0. Reset has priority over everything and aborts any scan position.
- Capture: idle_d registers idle_in each cycle. bcd_q <= bcd_in on the edge where idle_in=1 and idle_d=0 (rising edge of idle). No other load path. A constant high idle_in never reloads. bcd_in changes while idle_in=0 are ignored.
- Prescaler: tick_cnt increments each cycle. When tick_cnt==REFRESH_DIV-1, tick_cnt wraps to 0 and digit_idx advances 0..7, with 7 wrapping to 0. REFRESH_DIV=1 advances digit_idx every cycle.
- Outputs are registered. They are computed from the current digit_idx, bcd_q, enable, lzb and dp_in, so they lag digit_idx by one cycle. A newly captured bcd_q appears on the outputs one cycle after capture.
- Decode, active-high {g..a} patterns before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles A-F show a dash (g only), so seg=7'h3F after inversion.
- Blanking: with lzb=1, digit i (i>=1) is blanked when every digit j>=i has nibble 0 and dp_in[j]=0. Digit 0 is never blanked. A set dp_in bit stops blanking at that digit and all lower digits. Blanked digit: an=8'hFF, seg=7'h7F, dp=1.
- Visible digit: an = ~(1<<digit_idx), seg = ~pattern, dp = ~dp_in[digit_idx].
- enable=0: an=8'hFF, seg=7'h7F, dp=1. tick_cnt, digit_idx and capture continue unaffected.
- Simultaneous capture and digit advance: both occur on the same edge; the next output uses the new value.
- Exactly one anode is low at any time, or none.

Test Plan:
1. REFRESH_DIV=4. Reset, then enable=1, lzb=0. Expect an=FF, seg=7F during reset. After reset, an cycles FE, FD, FB, ..., 7F, FE with each value held 4 cycles, and seg=7'h40 ('0') on every digit.
2. bcd_in=32'h12345678, pulse idle_in 1->0->1. bcd_q updates on the rising edge. When an=FE, seg=~7F=7'h00 ('8'). When an=7F, seg=~06=7'h79 ('1'). Holding idle_in=1 with bcd_in=32'h99999999 produces no change.
3. lzb=1, bcd_q=32'h00000042. Digits 7..2 show an=FF. Digit 1 shows seg=~66=7'h19; digit 0 shows seg=~5B=7'h24. Then bcd_q=0: only digit 0 lit with '0' (seg=7'h40).
4. lzb=1, bcd_q=32'h00000005, dp_in=8'h02. Digit 1 lit as '0' with dp=0; digit 0 shows '5' (seg=7'h12) with dp=1; digits 7..2 blanked.
5. bcd_q nibble 4'hC at digit 3 -> seg=7'h3F when an=F7. enable=0 mid-scan -> an=FF immediately next cycle. Re-enable resumes at the already-advanced digit_idx, with no counter freeze.
6. Assert reset mid-scan at digit_idx=5 with bcd_q nonzero. Next edge: an=FF, seg=7F, bcd_q=0. After release, scan restarts at digit 0 and shows '0' on all digits (lzb=0).

Source files
------------

// File: rtl/bcd_display_driver.sv
// Purpose: latch the converter's packed BCD result and scan it onto an 8-digit common-anode 7-segment display.
// Latency: outputs are registered one cycle behind digit_idx; a new capture reaches the pins one cycle after it is latched.
// Backpressure: none; the capture window is the rising edge of idle_in, and the scan free-runs.
module bcd_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bcd_in,
    input  logic        idle_in,
    input  logic        enable,
    input  logic        lzb,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]      bcd_q;
    logic             idle_d;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       digit_idx;

    logic [3:0]       cur_nib;
    logic [6:0]       pattern;
    logic [7:0]       blank;
    logic [7:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    // Latch a fresh result only on the rising edge of the converter's idle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_d <= 1'b1;
            bcd_q  <= 32'h0;
        end else begin
            idle_d <= idle_in;
            if (idle_in && !idle_d) begin
                bcd_q <= bcd_in;
            end
        end
    end

    // Refresh prescaler: hold each digit REFRESH_DIV cycles, then step to the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            tick_cnt  <= tick_cnt + CNT_W'(1);
        end
    end

    // Blank mask: a digit is blanked while it and every digit above it are zero with no decimal point.
    always_comb begin
        logic run;
        blank = 8'h00;
        run   = lzb;
        for (int i = 7; i >= 1; i--) begin
            run      = run && (bcd_q[i*4 +: 4] == 4'h0) && !dp_in[i];
            blank[i] = run;
        end
    end

    // Seven-segment decode of the currently selected nibble; non-decimal nibbles show a dash.
    always_comb begin
        cur_nib = bcd_q[digit_idx*4 +: 4];
        case (cur_nib)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
    end

    // Pin values for the next cycle; disabled or blanked digits drive everything off.
    always_comb begin
        an_nxt  = 8'hFF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (enable && !blank[digit_idx]) begin
            an_nxt  = ~(8'h01 << digit_idx);
            seg_nxt = ~pattern;
            dp_nxt  = ~dp_in[digit_idx];
        end
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver with a 4-cycle refresh period.
// A cycle-level model predicts the pins every cycle; directed steps add literal checks.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_bcd_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bcd_in;
    logic        idle_in;
    logic        enable;
    logic        lzb;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    bcd_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .idle_in (idle_in),
        .enable  (enable),
        .lzb     (lzb),
        .dp_in   (dp_in),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [6:0] glyph [16];
    initial begin
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h6F;
        for (int k = 10; k < 16; k++) glyph[k] = 7'h40;
    end

    bit          m_valid = 1'b0;
    int          m_cyc;
    logic [31:0] m_bcd;
    logic        m_idle_prev;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    // Highest digit that must stay lit under blanking: top non-zero nibble or top dp request.
    function automatic int top_digit(input logic [31:0] v, input logic [7:0] d);
        int t = 0;
        for (int j = 0; j < 8; j++) begin
            if (((v >> (4 * j)) & 32'hF) != 0 || d[j]) t = j;
        end
        return t;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid     = 1'b1;
            m_cyc       = 0;
            m_bcd       = 32'h0;
            m_idle_prev = 1'b1;
            exp_an      = 8'hFF;
            exp_seg     = 7'h7F;
            exp_dp      = 1'b1;
        end else if (m_valid) begin
            int dig;
            int nib;
            dig = (m_cyc / DIV) % 8;
            nib = int'((m_bcd >> (4 * dig)) & 32'hF);
            if (!enable || (lzb && dig > top_digit(m_bcd, dp_in))) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = 8'hFF;
                exp_an[dig] = 1'b0;
                exp_seg = ~glyph[nib];
                exp_dp  = ~dp_in[dig];
            end
            if (idle_in && !m_idle_prev) m_bcd = bcd_in;
            m_idle_prev = idle_in;
            m_cyc++;
        end
    end

    // Every-cycle comparison of the pins against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("FAIL model t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                         $time, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_anode t=%0t an=%h expected at most one low bit", $time, an);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_lit(input string name, input logic [7:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
        checks++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL %s an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     name, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    task automatic wait_an(input string name, input logic [7:0] target);
        bit hit = 1'b0;
        for (int n = 0; n < 80 && !hit; n++) begin
            @(negedge clk);
            if (an === target) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout an=%h expected an=%h within 80 cycles", name, an, target);
        end
    endtask

    task automatic load(input logic [31:0] v);
        bcd_in  = v;
        idle_in = 1'b0;
        repeat (2) @(negedge clk);
        idle_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        bcd_in  = 32'h0;
        idle_in = 1'b1;
        enable  = 1'b1;
        lzb     = 1'b0;
        dp_in   = 8'h00;
        repeat (2) @(negedge clk);
        check_lit("reset_state", 8'hFF, 7'h7F, 1'b1);

        // 1: free-running scan of zeros
        reset = 1'b0;
        @(negedge clk);
        check_lit("first_digit", 8'hFE, 7'h40, 1'b1);
        repeat (DIV * 8 + 2) @(negedge clk);
        wait_an("t1_d7", 8'h7F);
        check_lit("t1_d7", 8'h7F, 7'h40, 1'b1);

        // 2: capture on idle rising edge, no reload while idle stays high
        load(32'h12345678);
        wait_an("t2_d0", 8'hFE);
        check_lit("t2_d0_eight", 8'hFE, 7'h00, 1'b1);
        wait_an("t2_d7", 8'h7F);
        check_lit("t2_d7_one", 8'h7F, 7'h79, 1'b1);
        bcd_in = 32'h99999999;
        repeat (DIV * 8) @(negedge clk);
        wait_an("t2_hold", 8'hFE);
        check_lit("t2_no_reload", 8'hFE, 7'h00, 1'b1);

        // 3: leading-zero blanking
        lzb = 1'b1;
        load(32'h00000042);
        wait_an("t3_d1", 8'hFD);
        check_lit("t3_d1_four", 8'hFD, 7'h19, 1'b1);
        wait_an("t3_d0", 8'hFE);
        check_lit("t3_d0_two", 8'hFE, 7'h24, 1'b1);
        load(32'h00000000);
        wait_an("t3_zero", 8'hFE);
        check_lit("t3_zero_d0", 8'hFE, 7'h40, 1'b1);
        repeat (DIV * 8) @(negedge clk);

        // 4: decimal point stops blanking
        dp_in = 8'h02;
        load(32'h00000005);
        wait_an("t4_d1", 8'hFD);
        check_lit("t4_d1_dp", 8'hFD, 7'h40, 1'b0);
        wait_an("t4_d0", 8'hFE);
        check_lit("t4_d0_five", 8'hFE, 7'h12, 1'b1);
        repeat (DIV * 8) @(negedge clk);

        // 5: dash for non-decimal nibble, enable gating mid-scan
        lzb   = 1'b0;
        dp_in = 8'h00;
        load(32'h0000C000);
        wait_an("t5_d3", 8'hF7);
        check_lit("t5_dash", 8'hF7, 7'h3F, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check_lit("t5_disabled", 8'hFF, 7'h7F, 1'b1);
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (DIV * 8) @(negedge clk);

        // 6: reset mid-scan
        load(32'h87654321);
        wait_an("t6_d5", 8'hDF);
        reset = 1'b1;
        @(negedge clk);
        check_lit("t6_reset", 8'hFF, 7'h7F, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_lit("t6_restart_d0", 8'hFE, 7'h40, 1'b1);
        wait_an("t6_d7", 8'h7F);
        check_lit("t6_cleared_d7", 8'h7F, 7'h40, 1'b1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
